// File: rtl/data_ram.sv
// Word-organised data RAM with a request/ready handshake, optional wait states,
// byte/halfword/word lanes, sign/zero extension and misalignment rejection.
module data_ram #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  rw,
  input  logic [1:0]            size,
  input  logic                  uns,
  input  logic [ADDR_WIDTH-1:0] adrs,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  ready,
  output logic                  misaligned
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state, next_state;
  logic [3:0]              count, next_count;
  logic                    accept, do_access, mis_in;

  logic                    rw_q, uns_q, mis_q;
  logic [1:0]              size_q;
  logic [ADDR_WIDTH-1:0]   adrs_q;
  logic [31:0]             din_q;

  logic [31:0]             mem [DEPTH];
  logic [ADDR_WIDTH-3:0]   widx;
  logic [1:0]              lane;
  logic [31:0]             rword, rdata, wdata;
  logic [7:0]              rbyte;
  logic [15:0]             rhalf;
  logic [3:0]              be;

  assign widx = adrs_q[ADDR_WIDTH-1:2];
  assign lane = adrs_q[1:0];

  // Size 11 is checked like a word.
  assign mis_in = ((size == 2'b01) && adrs[0]) || (size[1] && (adrs[1:0] != 2'b00));

  always_comb begin
    next_state = state;
    next_count = count;
    accept     = 1'b0;
    do_access  = 1'b0;
    case (state)
      IDLE: begin
        if (!cs) begin
          accept = 1'b1;
          if (mis_in) begin
            next_state = DONE;
          end else begin
            next_state = BUSY;
            next_count = 4'(WAIT_STATES);
          end
        end
      end
      BUSY: begin
        if (count != 4'd0) begin
          next_count = count - 4'd1;
        end else begin
          do_access  = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign ready      = (state == DONE);
  assign misaligned = (state == DONE) && mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= 4'd0;
      rw_q     <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      adrs_q   <= '0;
      din_q    <= 32'h0;
      mis_q    <= 1'b0;
      data_out <= 32'h0;
    end else begin
      state <= next_state;
      count <= next_count;
      if (accept) begin
        rw_q   <= rw;
        size_q <= size;
        uns_q  <= uns;
        adrs_q <= adrs;
        din_q  <= data_in;
        mis_q  <= mis_in;
      end
      if (do_access && !rw_q) data_out <= rdata;
    end
  end

  // Read path: select the lane and extend it to 32 bits.
  always_comb begin
    rword = mem[widx];
    rbyte = rword[{lane, 3'b000} +: 8];
    rhalf = lane[1] ? rword[31:16] : rword[15:0];
    rdata = rword;
    case (size_q)
      2'b00:   rdata = {{24{~uns_q & rbyte[7]}}, rbyte};
      2'b01:   rdata = {{16{~uns_q & rhalf[15]}}, rhalf};
      default: rdata = rword;
    endcase
  end

  // Write path: replicate the right-aligned data and enable only the addressed lanes.
  always_comb begin
    be    = 4'b1111;
    wdata = din_q;
    case (size_q)
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{din_q[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{din_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = din_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_access && rw_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// Drives three data_ram builds (0, 1 and 15 wait states) from one shared request bus
// and checks them against directed vectors and a byte-level reference model.
module tb_data_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        rw;
  logic [1:0]  size;
  logic        uns;
  logic [9:0]  adrs;
  logic [31:0] data_in;

  logic [31:0] dout [3];
  logic        rdy  [3];
  logic        mis  [3];

  int checks = 0;
  int errors = 0;

  logic [7:0]  model_mem [1024];
  logic [31:0] exp_dout;
  logic        exp_mis;

  int          obs_lat    [3];
  int          obs_pulses [3];
  logic        obs_mis    [3];
  logic [31:0] obs_dout   [3];

  typedef struct {
    logic        r;
    logic [1:0]  s;
    logic        u;
    logic [9:0]  a;
    logic [31:0] d;
    logic [31:0] exp_d;
    logic        exp_m;
  } vec_t;

  vec_t tbl [$];

  always #5 clk = ~clk;

  data_ram #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .cs(cs), .rw(rw), .size(size), .uns(uns), .adrs(adrs),
    .data_in(data_in), .data_out(dout[0]), .ready(rdy[0]), .misaligned(mis[0]));

  data_ram #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut1 (
    .clk(clk), .rst(rst), .cs(cs), .rw(rw), .size(size), .uns(uns), .adrs(adrs),
    .data_in(data_in), .data_out(dout[1]), .ready(rdy[1]), .misaligned(mis[1]));

  data_ram #(.ADDR_WIDTH(10), .WAIT_STATES(15)) dut15 (
    .clk(clk), .rst(rst), .cs(cs), .rw(rw), .size(size), .uns(uns), .adrs(adrs),
    .data_in(data_in), .data_out(dout[2]), .ready(rdy[2]), .misaligned(mis[2]));

  function automatic int wait_of(int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 15;
  endfunction

  function automatic int bytes_of(logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic is_mis(logic [1:0] s, logic [9:0] a);
    return ((int'(a) % bytes_of(s)) != 0);
  endfunction

  function automatic logic [31:0] model_read(logic [1:0] s, logic u, logic [9:0] a);
    logic [31:0] v = 32'h0;
    int n = bytes_of(s);
    for (int i = 0; i < n; i++) v = v | ({24'h0, model_mem[int'(a) + i]} << (8 * i));
    if (n < 4 && !u && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_write(logic [1:0] s, logic [9:0] a, logic [31:0] d);
    for (int i = 0; i < bytes_of(s); i++) model_mem[int'(a) + i] = 8'(d >> (8 * i));
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic scramble();
    rw      = 1'($urandom);
    size    = 2'($urandom);
    uns     = 1'($urandom);
    adrs    = 10'($urandom);
    data_in = $urandom;
  endtask

  // One single-cycle request, then a fixed observation window long enough for the
  // slowest build; the bus is scrambled throughout the window.
  task automatic applyStimulus(input logic r, input logic [1:0] s, input logic u,
                               input logic [9:0] a, input logic [31:0] d);
    exp_mis = is_mis(s, a);
    if (!exp_mis) begin
      if (r) model_write(s, a, d);
      else   exp_dout = model_read(s, u, a);
    end
    @(negedge clk);
    cs = 1'b0; rw = r; size = s; uns = u; adrs = a; data_in = d;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      obs_lat[i] = 0; obs_pulses[i] = 0; obs_mis[i] = 1'b0;
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      cs = 1'b1;
      scramble();
      for (int i = 0; i < 3; i++) begin
        if (rdy[i]) begin
          obs_pulses[i]++;
          if (obs_lat[i] == 0) begin
            obs_lat[i] = c;
            obs_mis[i] = mis[i];
          end
        end
      end
    end
    for (int i = 0; i < 3; i++) obs_dout[i] = dout[i];
  endtask

  task automatic check_txn(input string tag, input logic [31:0] ed, input logic em);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s w%0d latency", tag, wait_of(i)), 32'(obs_lat[i]),
                  em ? 32'd1 : 32'(wait_of(i) + 2));
      checkOutput($sformatf("%s w%0d pulses", tag, wait_of(i)), 32'(obs_pulses[i]), 32'd1);
      checkOutput($sformatf("%s w%0d misaligned", tag, wait_of(i)), {31'h0, obs_mis[i]}, {31'h0, em});
      checkOutput($sformatf("%s w%0d data_out", tag, wait_of(i)), obs_dout[i], ed);
    end
  endtask

  task automatic add_vec(logic r, logic [1:0] s, logic u, logic [9:0] a, logic [31:0] d,
                         logic [31:0] ed, logic em);
    vec_t v;
    v.r = r; v.s = s; v.u = u; v.a = a; v.d = d; v.exp_d = ed; v.exp_m = em;
    tbl.push_back(v);
  endtask

  initial begin
    logic [9:0] b2b [3];

    add_vec(1, 2'd2, 0, 10'h010, 32'hDEADBEEF, 32'h00000000, 0);
    add_vec(0, 2'd2, 0, 10'h010, 32'h0,        32'hDEADBEEF, 0);
    add_vec(1, 2'd2, 0, 10'h010, 32'h11223344, 32'hDEADBEEF, 0);
    add_vec(1, 2'd0, 0, 10'h013, 32'hAABBCC80, 32'hDEADBEEF, 0);
    add_vec(0, 2'd2, 0, 10'h010, 32'h0,        32'h80223344, 0);
    add_vec(0, 2'd0, 0, 10'h013, 32'h0,        32'hFFFFFF80, 0);
    add_vec(0, 2'd0, 1, 10'h013, 32'h0,        32'h00000080, 0);
    add_vec(0, 2'd1, 0, 10'h011, 32'h0,        32'h00000080, 1);
    add_vec(1, 2'd2, 0, 10'h012, 32'hCAFEF00D, 32'h00000080, 1);
    add_vec(0, 2'd2, 0, 10'h010, 32'h0,        32'h80223344, 0);
    add_vec(0, 2'd1, 0, 10'h012, 32'h0,        32'hFFFF8022, 0);
    add_vec(0, 2'd1, 1, 10'h010, 32'h0,        32'h00003344, 0);
    add_vec(1, 2'd2, 0, 10'h014, 32'h01020304, 32'h00003344, 0);
    add_vec(1, 2'd1, 0, 10'h016, 32'h9999ABCD, 32'h00003344, 0);
    add_vec(0, 2'd3, 0, 10'h014, 32'h0,        32'hABCD0304, 0);
    add_vec(0, 2'd3, 0, 10'h015, 32'h0,        32'hABCD0304, 1);
    add_vec(0, 2'd1, 0, 10'h014, 32'h0,        32'h00000304, 0);
    add_vec(0, 2'd0, 0, 10'h016, 32'h0,        32'hFFFFFFCD, 0);
    add_vec(0, 2'd1, 1, 10'h016, 32'h0,        32'h0000ABCD, 0);
    add_vec(1, 2'd0, 0, 10'h014, 32'h123456FF, 32'h0000ABCD, 0);
    add_vec(0, 2'd2, 0, 10'h014, 32'h0,        32'hABCD03FF, 0);

    rst = 1'b1; cs = 1'b1; rw = 1'b0; size = 2'd0; uns = 1'b0; adrs = '0; data_in = '0;
    exp_dout = 32'h0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset w%0d data_out", wait_of(i)), dout[i], 32'h0);
      checkOutput($sformatf("reset w%0d ready", wait_of(i)), {31'h0, rdy[i]}, 32'h0);
      checkOutput($sformatf("reset w%0d misaligned", wait_of(i)), {31'h0, mis[i]}, 32'h0);
    end
    rst = 1'b0;

    $display("[TB] directed vectors");
    foreach (tbl[k]) begin
      applyStimulus(tbl[k].r, tbl[k].s, tbl[k].u, tbl[k].a, tbl[k].d);
      check_txn($sformatf("vec%0d", k), tbl[k].exp_d, tbl[k].exp_m);
    end

    $display("[TB] randomized against reference model");
    for (int w = 0; w < 8; w++) begin
      applyStimulus(1'b1, 2'd2, 1'b0, 10'(16 + 4 * w), $urandom);
      check_txn($sformatf("init%0d", w), exp_dout, exp_mis);
    end
    for (int n = 0; n < 120; n++) begin
      applyStimulus(1'($urandom), 2'($urandom), 1'($urandom), 10'(16 + $urandom % 32), $urandom);
      check_txn($sformatf("rnd%0d", n), exp_dout, exp_mis);
    end

    $display("[TB] back-to-back reads with cs held low");
    b2b[0] = 10'h018; b2b[1] = 10'h01C; b2b[2] = 10'h020;
    @(negedge clk);
    cs = 1'b0; rw = 1'b0; size = 2'd2; uns = 1'b0; adrs = b2b[0];
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("b2b%0d busy ready", k), {31'h0, rdy[0]}, 32'h0);
      adrs = 10'($urandom);
      @(negedge clk);
      checkOutput($sformatf("b2b%0d done ready", k), {31'h0, rdy[0]}, 32'h1);
      checkOutput($sformatf("b2b%0d data_out", k), dout[0], model_read(2'd2, 1'b0, b2b[k]));
      adrs = 10'($urandom);
      @(negedge clk);
      checkOutput($sformatf("b2b%0d idle ready", k), {31'h0, rdy[0]}, 32'h0);
      if (k < 2) adrs = b2b[k + 1];
      else       cs = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_dout = 32'h0;

    $display("[TB] reset during BUSY");
    @(negedge clk);
    cs = 1'b0; rw = 1'b1; size = 2'd2; adrs = 10'h020; data_in = 32'h5A5A5A5A;
    @(posedge clk);
    @(negedge clk);
    cs = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) obs_pulses[i] = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (rdy[i]) obs_pulses[i]++;
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rstbusy w%0d pulses", wait_of(i)), 32'(obs_pulses[i]), 32'd0);
      checkOutput($sformatf("rstbusy w%0d data_out", wait_of(i)), dout[i], 32'h0);
    end
    applyStimulus(1'b0, 2'd2, 1'b0, 10'h020, 32'h0);
    check_txn("rstbusy readback", exp_dout, exp_mis);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, byte-address width; memory depth SHALL be 2^(ADDR_WIDTH-2) 32-bit words (default 256x32).
REQ-002 Parameter WAIT_STATES, default 1, range 0..15, extra access cycles inserted before each memory access.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cs  input  1  active-low request; sampled only in IDLE.
REQ-006 rw  input  1  0 = read, 1 = write.
REQ-007 size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-008 uns  input  1  1 = zero-extend sub-word reads, 0 = sign-extend.
REQ-009 adrs  input  ADDR_WIDTH  byte address.
REQ-010 data_in  input  32  write data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 data_out  output  32  read result, registered, right-aligned and extended.
REQ-012 ready  output  1  one-cycle pulse: request complete.
REQ-013 misaligned  output  1  qualifies ready: request rejected for misalignment.

Function
REQ-014 FSM states SHALL be IDLE, BUSY, DONE; reset state IDLE.
REQ-015 IDLE, cs=0 at edge: capture rw, size, uns, adrs, data_in; aligned -> BUSY with counter=WAIT_STATES; misaligned -> DONE with misaligned flag set.
REQ-016 Misaligned SHALL mean halfword with adrs[0]=1, or word/size 11 with adrs[1:0]!=00.
REQ-017 BUSY: counter!=0 -> decrement; counter==0 -> perform access at that edge, go DONE.
REQ-018 Access latency: ready high in the cycle beginning WAIT_STATES+2 edges after the accepting edge (2 for WAIT_STATES=0).
REQ-019 Misaligned latency: ready and misaligned high in the cycle after the accepting edge; no memory write; data_out unchanged.
REQ-020 DONE lasts exactly one cycle (ready=1), then IDLE; ready and misaligned SHALL be 0 in IDLE and BUSY.
REQ-021 Inputs changing during BUSY/DONE SHALL be ignored; captured values used.
REQ-022 cs held low continuously: next request accepted at first IDLE edge, giving one idle cycle between ready pulses.
REQ-023 Word index = adrs[ADDR_WIDTH-1:2]; lane = adrs[1:0]; little-endian (lane 0 = bits [7:0]).
REQ-024 Byte write SHALL modify only lane adrs[1:0]; halfword write only lanes {adrs[1],0} and {adrs[1],1}; word write all four; untouched lanes preserved.
REQ-025 Read SHALL load data_out with selected byte/half, sign- or zero-extended per uns; word reads ignore uns.
REQ-026 Write SHALL leave data_out unchanged.
REQ-027 data_out holds last read value until next successful read.

Reset
REQ-028 rst high SHALL immediately force IDLE, counter 0, ready 0, misaligned 0, data_out 0x00000000.
REQ-029 rst during BUSY SHALL discard the pending access; no memory write occurs.
REQ-030 Memory array contents SHALL NOT be reset.

Verification
REQ-031 WAIT_STATES=1: word write 0xDEADBEEF @0x010, then word read @0x010 -> each ready 3 cycles after accept, data_out=0xDEADBEEF, misaligned=0.
REQ-032 Byte write 0x80 @0x013 over 0x11223344 -> word read gives 0x80223344; byte read uns=0 @0x013 -> 0xFFFFFF80; uns=1 -> 0x00000080.
REQ-033 Halfword read @0x011 -> ready with misaligned=1 one cycle after accept; data_out unchanged; word write @0x012 -> memory unchanged.
REQ-034 Write accepted, rst pulsed during BUSY -> no ready pulse, target word unchanged on subsequent read, data_out=0 after reset.
REQ-035 cs held low, WAIT_STATES=0, three back-to-back reads -> ready pulses every 3 cycles, captured adrs changes mid-BUSY ignored.
REQ-036 WAIT_STATES=0 and WAIT_STATES=15 builds -> ready at 2 and 17 cycles after accept respectively.
